data_memory_lsu: RTL
====================

// Module: data_memory_lsu
// PURPOSE
//  - Byte-addressed RV32I data memory with a built-in load/store unit. Supports LB/LH/LW/LBU/LHU/SB/SH/SW.
//  - Provides byte-lane writes, sign/zero-extended loads, a valid/ready request/response handshake and a programmable response latency.
//  - Sits between the execute stage and data storage. It is the parametrised successor of the plain word-only data memory.
// PARAMETERS
//  - AW       32      address width
//  - BASE     'h1000  first byte address mapped
//  - SIZE     1024    bytes of storage; power of two, >=4
//  - LAT      1       cycles from request accept to rsp_valid; legal 1..8
// PORTS
//  - clk        in   1   clock; all state changes on rising edge
//  - rst_n      in   1   reset; asynchronous assert, active-low
//  - req_valid  in   1   request present
//  - req_ready  out  1   block can accept a request
//  - req_write  in   1   1=store, 0=load
//  - req_funct3 in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  - req_addr   in   AW  byte address
//  - req_wdata  in   32  store data, LSB-aligned (SB uses [7:0], SH uses [15:0])
//  - rsp_valid  out  1   response present
//  - rsp_ready  in   1   consumer takes response
//  - rsp_rdata  out  32  extended load data; 0 for stores and errors
//  - rsp_err    out  1   request faulted; valid only with rsp_valid
// BEHAVIOUR
//  - Single outstanding request. FSM states: IDLE, WAIT, RESP.
//  - Accept happens when req_valid & req_ready. req_ready = (state==IDLE).
//  - IDLE --accept--> RESP if LAT==1, else WAIT with cnt=LAT-1.
//    - WAIT decrements cnt each cycle and goes to RESP when cnt reaches 1.
//  - RESP: rsp_valid=1 and outputs are held stable until rsp_ready. Then go to IDLE.
//    - No new accept occurs in the same cycle as a RESP handshake.
//  - Result: rsp_valid rises exactly LAT cycles after the accept edge.
//  - Store: bytes are written on the accept edge, little-endian. Only lanes addr..addr+n-1 change; n = 1, 2 or 4.
//  - Load: bytes are sampled on the accept edge and latched. A later store cannot alter a pending response.
//  - Extension:
//    - B sign-extends from bit 7; H sign-extends from bit 15.
//    - BU/HU zero-extend; W is passed through.
//  - Offset: addr-BASE is taken modulo SIZE, so the index is log2(SIZE) bits wide.
//  - Reset:
//    - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    - Storage contents are not reset.
//    - Reset mid-WAIT/RESP discards the response. A store already accepted stays committed.
//  - req_* inputs are ignored while req_ready=0.
// CONFIGURATION
//  - Macro DMEM_LSU_ERR_EN.
//  - When defined, a request faults (rsp_err=1, rsp_rdata=0, no write) if any of these hold:
//    - misaligned: H with addr[0]!=0, or W with addr[1:0]!=0;
//    - out of range: addr<BASE or addr+n-1>BASE+SIZE-1;
//    - illegal funct3 (011, 110, 111, or store with funct3[2]=1).
//    - A faulting request still completes the normal LAT handshake.
//  - When undefined:
//    - rsp_err is tied 0.
//    - Address low bits are forced aligned (H clears bit0, W clears [1:0]).
//    - The offset wraps modulo SIZE.
//    - Illegal funct3 is treated as W; store funct3[2] is ignored.
// TESTING
//  - Reset: rst_n=0 mid-WAIT (LAT=3) -> next cycle rsp_valid=0, req_ready=1; a rsp_ready pulse produces no response.
//  - SW 0x8899AABB @0x1000, then LB @0x1000 -> rdata 0xFFFFFFBB. LBU @0x1003 -> 0x00000088. LH @0x1002 -> 0xFFFF8899.
//  - SB 0x11 @0x1001 over 0x8899AABB, then LW @0x1000 -> 0x889911BB (other lanes untouched).
//  - LAT=4: accept at cycle 0 -> rsp_valid at cycle 4. Hold rsp_ready=0 for 3 cycles -> rdata stable, req_ready=0 throughout.
//  - ERR_EN: LW @0x1002 -> err=1, rdata=0. SW @0x0FFC -> err=1, memory unchanged. SW @0x13FC -> err=0.
//  - No ERR_EN: LW @0x1002 returns the word at 0x1000. SW @0x1400 (SIZE=1024) writes offset 0.

Source files
------------

// File: rtl/data_memory_lsu.sv
// RV32I byte-addressed data memory with load/store unit and LAT-cycle response.
// Define DMEM_LSU_ERR_EN to fault misaligned, out-of-range and illegal requests.
module data_memory_lsu #(
    parameter int unsigned   AW   = 32,
    parameter logic [AW-1:0] BASE = 'h1000,
    parameter int unsigned   SIZE = 1024,
    parameter int unsigned   LAT  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);
    localparam int unsigned IW = $clog2(SIZE);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [7:0]  mem_q [SIZE];

    logic          accept;
    logic          is_b;
    logic          is_h;
    logic          err;
    logic [3:0]    lane;
    logic [IW-1:0] off;
    logic [IW-1:0] idx [4];
    logic [31:0]   ld;
    logic          unused_addr;

    assign accept = req_valid && ready_q;
    assign is_b   = (req_funct3[1:0] == 2'b00);
    assign is_h   = (req_funct3[1:0] == 2'b01);
    assign lane   = is_b ? 4'b0001 : (is_h ? 4'b0011 : 4'b1111);

`ifdef DMEM_LSU_ERR_EN
    logic [AW:0] first_a;
    logic [AW:0] last_a;
    logic [AW:0] top_a;
    logic        misal;
    logic        oor;
    logic        ill;

    // Range check runs one bit wider so addr+n-1 cannot wrap past zero.
    assign first_a = {1'b0, req_addr};
    assign last_a  = first_a + (AW+1)'(is_b ? 0 : (is_h ? 1 : 3));
    assign top_a   = {1'b0, BASE} + (AW+1)'(SIZE - 1);
    assign misal   = (is_h && req_addr[0])
                   || (!is_b && !is_h && (req_addr[1:0] != 2'b00));
    assign oor     = (req_addr < BASE) || (last_a > top_a);
    assign ill     = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                   || (req_write && req_funct3[2]);
    assign err     = misal || oor || ill;
    assign off     = req_addr[IW-1:0] - BASE[IW-1:0];
    assign unused_addr = 1'b0;
`else
    logic [AW-1:0] addr_al;

    assign err     = 1'b0;
    assign addr_al = {req_addr[AW-1:2],
                      req_addr[1] & (is_b | is_h),
                      req_addr[0] & is_b};
    assign off     = addr_al[IW-1:0] - BASE[IW-1:0];
    assign unused_addr = ^addr_al[AW-1:IW];
`endif

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = off + IW'(k);
        end
    end

    always_comb begin
        ld = {mem_q[idx[3]], mem_q[idx[2]], mem_q[idx[1]], mem_q[idx[0]]};
        if (is_b) begin
            ld = req_funct3[2] ? {24'd0, mem_q[idx[0]]}
                               : {{24{mem_q[idx[0]][7]}}, mem_q[idx[0]]};
        end else if (is_h) begin
            ld = req_funct3[2] ? {16'd0, mem_q[idx[1]], mem_q[idx[0]]}
                               : {{16{mem_q[idx[1]][7]}},
                                  mem_q[idx[1]], mem_q[idx[0]]};
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !err) begin
            for (int k = 0; k < 4; k++) begin
                if (lane[k]) mem_q[idx[k]] <= req_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        err_q   <= err;
                        rdata_q <= (req_write || err) ? '0 : ld;
                        if (LAT <= 1) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule
